// File: rtl/dfdd_pkg.sv
// Shared dfdd pipeline types: pixel/coordinate typedefs, the tagged-pixel struct
// and the coordinate generator's FSM state type.
package dfdd_pkg;

  typedef logic [15:0] coord_t;
  typedef logic [15:0] fp16_t;

  typedef struct packed {
    fp16_t  data;
    coord_t col;
    coord_t row;
    logic   sof;
    logic   eol;
    logic   eof;
  } pix_tag_t;

  typedef enum logic {StIdle, StActive} coord_state_t;

  // A zero frame dimension behaves as a single pixel/line.
  function automatic coord_t dim_clamp(input coord_t d);
    return (d == '0) ? coord_t'(1) : d;
  endfunction

endpackage

// File: rtl/dfdd_skid_buffer.sv
// Two-entry valid/ready skid buffer with registered outputs and a registered
// ready, generic over the payload type.
module dfdd_skid_buffer
  import dfdd_pkg::*;
#(
  parameter type T = pix_tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  T     in_data,
  input  logic in_valid,
  output logic in_ready,
  output T     out_data,
  output logic out_valid,
  input  logic out_ready
);

  T     out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;
  logic in_fire, out_free;

  assign in_ready  = ready_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    in_fire      = in_valid && ready_q;
    out_free     = !out_valid_q || out_ready;
    if (out_free) begin
      // ready_q is low whenever the skid slot is full, so no input can race it.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_data;
      end
    end else if (in_fire) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: rtl/radial_pixel_coord_gen.sv
// Tags each pixel of a raw stream with column/row and frame/line markers ahead
// of the radial zone coefficient lookup.
module radial_pixel_coord_gen
  import dfdd_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COORD_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [COORD_W-1:0] width_i,
  input  logic [COORD_W-1:0] height_i,
  input  logic               sof_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [COORD_W-1:0] col_o,
  output logic [COORD_W-1:0] row_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               sync_err_o
);

  coord_state_t state_q, state_d;
  coord_t   col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
  coord_t   cur_col, cur_row, cur_w, cur_h;
  logic     err_q, err_d, restart, fwd, skid_ready, last_col, last_row;
  pix_tag_t in_tag, out_tag;

  assign ready_o    = skid_ready;
  assign sync_err_o = err_q;
  assign data_o     = DATA_W'(out_tag.data);
  assign col_o      = COORD_W'(out_tag.col);
  assign row_o      = COORD_W'(out_tag.row);
  assign sof_o      = out_tag.sof;
  assign eol_o      = out_tag.eol;
  assign eof_o      = out_tag.eof;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    err_d   = err_q;

    restart = valid_i && skid_ready && sof_i;
    // Outside a frame only a sof pixel is forwarded; the rest are accepted and dropped.
    fwd     = valid_i && ((state_q == StActive) || sof_i);

    cur_w   = restart ? dim_clamp(coord_t'(width_i))  : w_q;
    cur_h   = restart ? dim_clamp(coord_t'(height_i)) : h_q;
    cur_col = restart ? '0 : col_q;
    cur_row = restart ? '0 : row_q;

    last_col = (cur_col == cur_w - coord_t'(1));
    last_row = (cur_row == cur_h - coord_t'(1));

    in_tag.data = fp16_t'(data_i);
    in_tag.col  = cur_col;
    in_tag.row  = cur_row;
    in_tag.sof  = (cur_col == '0) && (cur_row == '0);
    in_tag.eol  = last_col;
    in_tag.eof  = last_col && last_row;

    if (fwd && skid_ready) begin
      w_d     = cur_w;
      h_d     = cur_h;
      col_d   = last_col ? '0 : cur_col + coord_t'(1);
      row_d   = !last_col ? cur_row : (last_row ? '0 : cur_row + coord_t'(1));
      state_d = (last_col && last_row) ? StIdle : StActive;
    end

    if (restart && (state_q == StActive)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= coord_t'(1);
      h_q     <= coord_t'(1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      err_q   <= err_d;
    end
  end

  dfdd_skid_buffer #(
    .T(pix_tag_t)
  ) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .in_data   (in_tag),
    .in_valid  (fwd),
    .in_ready  (skid_ready),
    .out_data  (out_tag),
    .out_valid (valid_o),
    .out_ready (ready_i)
  );

endmodule

// File: tb/tb_radial_pixel_coord_gen.sv
// Randomised-data bench for radial_pixel_coord_gen against a frame-level model
// that derives coordinates from the pixel index within the frame.
module tb_radial_pixel_coord_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] width_i, height_i, data_i, data_o, col_o, row_o;
  logic        sof_i, valid_i, ready_o, sof_o, eol_o, eof_o, valid_o, ready_i, sync_err_o;

  int checks = 0;
  int errors = 0;

  // Expected output pixels, packed as {data, col, row, sof, eol, eof}.
  logic [50:0] q[$];
  bit          in_frame = 1'b0;
  bit          err_m    = 1'b0;
  longint      n_pix, fw, fh;
  logic [50:0] snap;
  bit          snap_v = 1'b0;

  always #5 clk_i = ~clk_i;

  radial_pixel_coord_gen #(
    .DATA_W (16),
    .COORD_W(16)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .width_i   (width_i),
    .height_i  (height_i),
    .sof_i     (sof_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .col_o     (col_o),
    .row_o     (row_o),
    .sof_o     (sof_o),
    .eol_o     (eol_o),
    .eof_o     (eof_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sync_err_o(sync_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_in(input bit s, input logic [15:0] d);
    longint col, row;
    if (s) begin
      if (in_frame) err_m = 1'b1;
      fw       = (width_i == 0) ? 1 : longint'(width_i);
      fh       = (height_i == 0) ? 1 : longint'(height_i);
      n_pix    = 0;
      in_frame = 1'b1;
    end else if (!in_frame) begin
      return;
    end
    col = n_pix % fw;
    row = n_pix / fw;
    q.push_back({d, 16'(col), 16'(row), n_pix == 0, col == fw - 1, n_pix == fw * fh - 1});
    if (n_pix == fw * fh - 1) in_frame = 1'b0;
    n_pix++;
  endtask

  // One cycle, acting at the negative edge.
  task automatic tick(input bit v, input bit s, input logic [15:0] d, input bit r);
    chk("valid_o", valid_o, q.size() > 0);
    chk("ready_o", ready_o, q.size() < 2);
    chk("sync_err_o", sync_err_o, err_m);
    if (snap_v) chk("stall_stable", {data_o, col_o, row_o, sof_o, eol_o, eof_o}, snap);
    valid_i = v;
    sof_i   = s;
    data_i  = d;
    ready_i = r;
    snap_v  = 1'b0;
    if (valid_o && ready_i) begin
      if (q.size() > 0) begin
        chk("pixel", {data_o, col_o, row_o, sof_o, eol_o, eof_o}, q[0]);
        void'(q.pop_front());
      end
    end else if (valid_o) begin
      snap   = {data_o, col_o, row_o, sof_o, eol_o, eof_o};
      snap_v = 1'b1;
    end
    if (v && ready_o) model_in(s, d);
    @(negedge clk_i);
  endtask

  function automatic bit ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      2:       return $urandom_range(0, 2) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Offer cnt pixels back-to-back; sof_a == -2 tags every pixel with sof_i.
  task automatic send(input int cnt, input int sof_a, input int sof_b, input int rmode);
    int  sent = 0;
    int  k    = 0;
    bit  acc, s;
    while (sent < cnt && k < cnt * 8 + 20) begin
      acc = ready_o;
      s   = (sof_a == -2) || (sent == sof_a) || (sent == sof_b);
      tick(1'b1, s, 16'($urandom), ready_for(rmode, k));
      if (acc) sent++;
      k++;
    end
    chk("send_done", sent, cnt);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 0);
    chk("rst_outputs", {data_o, col_o, row_o, sof_o, eol_o, eof_o, sync_err_o}, 0);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    in_frame = 1'b0;
    err_m    = 1'b0;
    snap_v   = 1'b0;
    @(negedge clk_i);
    check_reset_outputs();
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    valid_i  = 1'b0;
    sof_i    = 1'b0;
    data_i   = '0;
    ready_i  = 1'b1;
    width_i  = 16'd4;
    height_i = 16'd2;
    rst_n_i  = 1'b1;
    @(negedge clk_i);
    do_reset();

    // 4x2 frame, downstream always ready.
    send(8, 0, -1, 0);
    drain(3);

    // Same frame, ready_i toggling 1,0,0,1.
    send(8, 0, -1, 1);
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b0, 16'h0, ready_for(1, k));
    drain(2);

    // Pixels without sof_i are dropped, then a 2x1 frame.
    width_i  = 16'd2;
    height_i = 16'd1;
    send(3, -1, -1, 0);
    send(2, 0, -1, 0);
    drain(3);

    // 4x4 frame resynchronised at (2,1).
    width_i  = 16'd4;
    height_i = 16'd4;
    send(22, 0, 6, 0);
    drain(3);

    // Zero dimensions behave as 1x1.
    width_i  = 16'd0;
    height_i = 16'd0;
    send(4, -2, -1, 0);
    drain(3);

    // Reset with two pixels held in the buffer.
    width_i  = 16'd4;
    height_i = 16'd2;
    send(2, 0, -1, 3);
    do_reset();
    send(1, -1, -1, 0);
    send(3, 0, -1, 0);
    drain(3);

    // Random traffic, small frames, occasional sof_i.
    for (int i = 0; i < 400; i++) begin
      width_i  = 16'($urandom_range(0, 5));
      height_i = 16'($urandom_range(0, 3));
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 16'($urandom),
           ready_for(2, i));
    end
    drain(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
